// File: rtl/nes_controller_device.sv
// NES-style controller device: snapshots eight buttons on the host latch and
// shifts them out active-low on the host shift clock, one bit per rising edge.
module nes_controller_device #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_buttons,
   input  logic       i_controller_latch,
   input  logic       i_controller_clock,
   output logic       o_controller_data,
   output logic [7:0] o_latched_buttons,
   output logic       o_poll_done,
   output logic [1:0] fsm_state,
   output logic [3:0] bit_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [SYNC_STAGES-1:0] latch_sync;
   logic [SYNC_STAGES-1:0] clock_sync;
   logic                   latch_hist;
   logic                   clock_hist;
   logic                   latch_s;
   logic                   clock_s;
   logic                   latch_fall;
   logic                   clock_rise;

   logic [7:0] sr;
   logic [3:0] cnt;

   logic load_sr;
   logic shift_sr;
   logic capture;
   logic finish;

   // Host pins are asynchronous; only the last synchronizer stage is trusted.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         latch_sync <= '0;
         clock_sync <= '0;
         latch_hist <= 1'b0;
         clock_hist <= 1'b0;
      end else begin
         latch_sync <= {latch_sync[SYNC_STAGES-2:0], i_controller_latch};
         clock_sync <= {clock_sync[SYNC_STAGES-2:0], i_controller_clock};
         latch_hist <= latch_s;
         clock_hist <= clock_s;
      end
   end

   assign latch_s    = latch_sync[SYNC_STAGES-1];
   assign clock_s    = clock_sync[SYNC_STAGES-1];
   assign latch_fall = latch_hist & ~latch_s;
   assign clock_rise = clock_s & ~clock_hist;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A high latch overrides everything, so a coincident clock edge is dropped.
   always_comb begin
      next_state = state;
      load_sr    = 1'b0;
      shift_sr   = 1'b0;
      capture    = 1'b0;
      finish     = 1'b0;
      if (latch_s) begin
         next_state = ST_LOAD;
         load_sr    = 1'b1;
      end else begin
         case (state)
            ST_LOAD: begin
               if (latch_fall) begin
                  next_state = ST_SHIFT;
                  capture    = 1'b1;
               end
            end
            ST_SHIFT: begin
               if (clock_rise) begin
                  shift_sr = 1'b1;
                  if (cnt == 4'd7) begin
                     finish     = 1'b1;
                     next_state = ST_IDLE;
                  end
               end
            end
            default: begin
               next_state = state;
            end
         endcase
      end
   end

   // Zero fill means "released" once the eight real bits are gone.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sr                <= '0;
         cnt               <= '0;
         o_latched_buttons <= '0;
         o_poll_done       <= 1'b0;
         o_controller_data <= 1'b1;
      end else begin
         if (load_sr) begin
            sr  <= i_buttons;
            cnt <= 4'd0;
         end else if (shift_sr) begin
            sr  <= {1'b0, sr[7:1]};
            cnt <= cnt + 4'd1;
         end
         if (capture) begin
            o_latched_buttons <= sr;
         end
         o_poll_done       <= finish;
         o_controller_data <= (state == ST_IDLE) ? 1'b1 : ~sr[0];
      end
   end

   assign fsm_state = state;
   assign bit_count = cnt;

endmodule

// File: tb/tb_nes_controller_device.sv
// Randomized bench for nes_controller_device: a host-level model predicts the
// serial line and snapshots; monitors compare against queued expectations.
module tb_nes_controller_device;

   localparam int SYNC_STAGES = 2;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;

   logic       clk = 1'b0;
   logic       i_rst_n;
   logic [7:0] i_buttons;
   logic       i_controller_latch;
   logic       i_controller_clock;
   logic       o_controller_data;
   logic [7:0] o_latched_buttons;
   logic       o_poll_done;
   logic [1:0] fsm_state;
   logic [3:0] bit_count;

   logic [8:0] exp_q[$];
   logic [7:0] done_q[$];
   int         checks = 0;
   int         errors = 0;
   event       sample_ev;

   // Host-level model: which button index the host would read next.
   logic [7:0] m_snap = 8'h00;
   logic [7:0] m_latched = 8'h00;
   bit         m_active = 1'b0;
   bit         m_latch = 1'b0;
   int         m_pos = 0;

   always #5 clk = ~clk;

   nes_controller_device #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk                (clk),
      .i_rst_n            (i_rst_n),
      .i_buttons          (i_buttons),
      .i_controller_latch (i_controller_latch),
      .i_controller_clock (i_controller_clock),
      .o_controller_data  (o_controller_data),
      .o_latched_buttons  (o_latched_buttons),
      .o_poll_done        (o_poll_done),
      .fsm_state          (fsm_state),
      .bit_count          (bit_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_data();
      if (!m_active || m_pos >= 8) return 1'b1;
      return ~m_snap[m_pos];
   endfunction

   // Data-line monitor: one expectation per sample strobe.
   initial begin
      logic [8:0] e;
      forever begin
         @(sample_ev);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sample_no_expectation: got strobe expected queued value at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("controller_data", {31'd0, o_controller_data}, {31'd0, e[0]});
            check("latched_buttons", {24'd0, o_latched_buttons}, {24'd0, e[8:1]});
         end
      end
   end

   // Poll-complete monitor: every pulse must match a completed model poll.
   always @(negedge clk) begin
      if (o_poll_done === 1'b1) begin
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_poll_done: got 1 expected 0 at %0t", $time);
         end else begin
            check("poll_done_latched", {24'd0, o_latched_buttons}, {24'd0, done_q.pop_front()});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic settle(input int k);
      repeat (k) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic observe();
      exp_q.push_back({m_latched, exp_data()});
      ->sample_ev;
      #1;
   endtask

   task automatic latch_high(input logic [7:0] b);
      i_buttons = b;
      i_controller_latch = 1'b1;
      m_snap = b;
      m_active = 1'b1;
      m_pos = 0;
      m_latch = 1'b1;
      settle(SYNC_STAGES + 2);
      observe();
   endtask

   task automatic latch_change(input logic [7:0] b);
      i_buttons = b;
      m_snap = b;
      settle(SYNC_STAGES + 2);
      observe();
   endtask

   task automatic latch_low();
      i_controller_latch = 1'b0;
      m_latched = m_snap;
      m_latch = 1'b0;
      settle(SYNC_STAGES + 2);
      observe();
   endtask

   task automatic clock_pulse(input bit timed);
      logic [8:0] old;
      old = {m_latched, exp_data()};
      i_controller_clock = 1'b1;
      if (m_active && !m_latch) begin
         m_pos++;
         if (m_pos == 8) begin
            done_q.push_back(m_snap);
            m_active = 1'b0;
         end
      end
      if (timed) begin
         settle(SYNC_STAGES + 1);
         exp_q.push_back(old);
         ->sample_ev;
         #1;
         settle(1);
      end else begin
         settle(SYNC_STAGES + 2);
      end
      observe();
      if (!m_latch) i_buttons = 8'($urandom);
      i_controller_clock = 1'b0;
      settle(SYNC_STAGES + 2);
      observe();
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) clock_pulse(1'b0);
   endtask

   task automatic latch_and_clock(input logic [7:0] b);
      i_buttons = b;
      i_controller_latch = 1'b1;
      i_controller_clock = 1'b1;
      m_snap = b;
      m_active = 1'b1;
      m_pos = 0;
      m_latch = 1'b1;
      settle(SYNC_STAGES + 2);
      observe();
      check("simul_state", {30'd0, fsm_state}, {30'd0, S_LOAD});
      check("simul_count", {28'd0, bit_count}, 32'd0);
      i_controller_clock = 1'b0;
      settle(SYNC_STAGES + 2);
      observe();
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #3;
      i_rst_n = 1'b0;
      m_active = 1'b0;
      m_latched = 8'h00;
      m_latch = 1'b0;
      m_pos = 0;
      #1;
      observe();
      check("reset_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
      check("reset_count", {28'd0, bit_count}, 32'd0);
      check("reset_poll_done", {31'd0, o_poll_done}, 32'd0);
      settle(3);
      i_rst_n = 1'b1;
      settle(2);
      clock_pulse(1'b0);
      check("post_reset_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
   endtask

   initial begin
      int n;
      i_rst_n = 1'b0;
      i_buttons = 8'h00;
      i_controller_latch = 1'b0;
      i_controller_clock = 1'b0;
      settle(3);
      observe();
      check("init_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
      check("init_count", {28'd0, bit_count}, 32'd0);
      i_rst_n = 1'b1;
      settle(2);

      // Clock before any latch is ignored.
      clock_pulse(1'b0);

      // Normal poll, first edge checked for exact latency.
      latch_high(8'h85);
      latch_low();
      clock_pulse(1'b1);
      pulses(7);
      check("normal_count", {28'd0, bit_count}, 32'd8);
      check("normal_state", {30'd0, fsm_state}, {30'd0, S_IDLE});

      // Buttons followed while latch held; clock during latch ignored.
      latch_high(8'h01);
      clock_pulse(1'b0);
      latch_change(8'h00);
      latch_low();
      pulses(8);

      // Abort after three edges, then a full all-released poll.
      latch_high(8'hFF);
      latch_low();
      pulses(3);
      latch_high(8'h00);
      latch_low();
      pulses(8);

      // Extra edges past the eighth.
      latch_high(8'hFF);
      latch_low();
      pulses(12);
      check("extra_count", {28'd0, bit_count}, 32'd8);

      // Coincident latch and clock edges during a shift.
      latch_high(8'h3C);
      latch_low();
      pulses(2);
      latch_and_clock(8'hA5);
      latch_low();
      pulses(8);

      // Reset in the middle of a shift.
      latch_high(8'h5A);
      latch_low();
      pulses(4);
      reset_pulse();

      for (int it = 0; it < 30; it++) begin
         latch_high(8'($urandom));
         if ($urandom_range(0, 3) == 0) latch_change(8'($urandom));
         latch_low();
         n = $urandom_range(0, 12);
         pulses(n);
         if ($urandom_range(0, 9) == 0) reset_pulse();
      end

      settle(5);
      check("done_q_empty", done_q.size(), 32'd0);
      check("exp_q_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
